muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer and iterative datapath for RV32M multiply/divide/remainder operations.
- Accepts an issue when the decode stage flags muldiv with a one-hot muldiv_op, runs a shift-add or restoring-division loop, and returns one result with a single-cycle valid pulse.
- Sits beside the ALU in execute; the pipeline stalls on busy.

Parameters:
- BITS_PER_CYCLE, default 1: iteration bits retired per cycle. Legal values are 1, 2 and 4. ITER = 32/BITS_PER_CYCLE.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- issue  input  1  start request (decoder muldiv AND stage valid)
- op  input  8  one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}, bit0=mul
- rs1  input  32  operand a
- rs2  input  32  operand b
- kill  input  1  flush; abort any operation in flight
- ready  output  1  high only in IDLE; issue is accepted only when ready=1
- busy  output  1  high in MUL, DIV, FIX
- result  output  32  final value; held until the next accepted issue
- result_valid  output  1  one-cycle pulse when result becomes valid

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, result=0, result_valid=0, counter=0. Reset mid-operation discards the operation with no result_valid.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - issue=1 with mul* op: latch operands and op, then go to MUL.
  - issue=1 with div*/rem* op: check the special cases before going to DIV.
- Special cases, taken from IDLE straight to DONE:
  - Divide by zero (rs2=0): div/divu give 0xFFFFFFFF; rem/remu give rs1.
  - Signed overflow (div/rem with rs1=0x80000000, rs2=0xFFFFFFFF): div gives 0x80000000, rem gives 0.
  - Otherwise go to DIV.
- Sign handling:
  - Signed operands are converted to magnitudes at issue.
  - mulhsu: rs1 signed, rs2 unsigned.
  - Result sign: product sign = sa XOR sb; quotient sign = sa XOR sb; remainder sign = sa.
- MUL: 64-bit accumulator. Each cycle retires BITS_PER_CYCLE multiplier bits (shift-add). counter increments and leaves to FIX after ITER cycles.
- DIV: restoring division, BITS_PER_CYCLE quotient bits per cycle. Same counter rule, then FIX.
- FIX: apply two's-complement negation per the sign rules, select the result, go to DONE.
  - mul: low 32 bits.
  - mulh/mulhsu/mulhu: high 32 bits.
  - div/divu: quotient.
  - rem/remu: remainder.
- DONE: result_valid=1 for exactly this cycle; next state IDLE.
- ready=1 only in IDLE; DONE is not ready. An issue presented while not ready is ignored; the pipeline must hold it.
- Latency, with the issue accepted at cycle T:
  - Normal ops: result_valid at T+ITER+2 (T+34 for BITS_PER_CYCLE=1).
  - Special cases: result_valid at T+1.
- kill:
  - In MUL/DIV/FIX/DONE: next state IDLE, result_valid suppressed in that cycle, result unchanged.
  - kill has priority over issue in the same cycle; no accept.
- Illegal op (not one-hot, or zero) with issue=1: treated as mul. The decoder guarantees one-hot.
- Counter width: clog2(ITER)+1 bits. It wraps never and is cleared on every accept.

Optional Feature:
- Macro: MULDIV_SEQ_FAST_MUL_EN.
- Defined:
  - Multiply ops use a single 33x33 signed multiplier registered in MUL for one cycle, then FIX.
  - mul latency becomes T+3.
  - Divide path is unchanged.
- Not defined: iterative multiply as described above. No `*` operator is inferred.

Test Plan:
- mul rs1=7, rs2=-3 (0xFFFFFFFD) -> result=0xFFFFFFEB, result_valid exactly at T+34 (BITS_PER_CYCLE=1); 3 with FAST_MUL_EN.
- mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 100/7 -> 14; remu 100/7 -> 2.
- div 5/0 -> 0xFFFFFFFF at T+1; remu 5/0 -> 5; div 0x80000000/-1 -> 0x80000000; rem of the same -> 0.
- Issue div 100/7, then kill at T+10 -> no result_valid, ready=1 at T+11, result keeps its prior value; a new issue at T+11 completes normally.
- Issue held high continuously -> exactly one accept per operation, ready low from T+1 through DONE; reset asserted mid-DIV -> all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle for the muldiv_seq multiply/divide sequencer.
// The master side drives the issue fields and kill; the slave side returns status and result.
interface muldiv_seq_if;
  // issue is accepted on a rising edge only when issue=1, ready=1 and kill=0.
  // result_valid is a one-cycle pulse; result holds its value after the pulse.
  logic        issue;
  logic [7:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        ready;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic [2:0]  dbg_state;

  modport master (
    output issue, op, rs1, rs2, kill,
    input  ready, busy, result, result_valid, dbg_state
  );

  modport slave (
    input  issue, op, rs1, rs2, kill,
    output ready, busy, result, result_valid, dbg_state
  );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide/remainder sequencer: iterative shift-add multiply and restoring divide.
// Optional MULDIV_SEQ_FAST_MUL_EN replaces the iterative multiply with one registered 33x33 multiply.
module muldiv_seq #(
  parameter int BITS_PER_CYCLE = 1  // 1, 2 or 4
) (
  input logic          clock,
  input logic          reset,
  muldiv_seq_if.slave  bus
);
  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    code_q;
  logic          neg_main_q, neg_rem_q;
  logic [31:0]   ma_q, mb_q;
  logic [63:0]   acc;
  logic [CW-1:0] cnt;
  logic [31:0]   fixed_q, result_q;

  // Op code index: 0 mul .. 7 remu; anything not strictly one-hot decodes as mul.
  logic        legal;
  logic [2:0]  code;
  logic        is_div, signed_a, signed_b, sa, sb;
  logic [31:0] abs_a, abs_b;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_val;
  logic        accept;

  always_comb begin
    legal = (bus.op != 8'd0) && ((bus.op & (bus.op - 8'd1)) == 8'd0);
    code  = 3'd0;
    if (legal) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.op[i]) code = 3'(i);
      end
    end
    is_div   = code[2];
    signed_a = (code == 3'd1) || (code == 3'd2) || (code == 3'd4) || (code == 3'd6);
    signed_b = (code == 3'd1) || (code == 3'd4) || (code == 3'd6);
    sa       = signed_a && bus.rs1[31];
    sb       = signed_b && bus.rs2[31];
    abs_a    = sa ? (32'd0 - bus.rs1) : bus.rs1;
    abs_b    = sb ? (32'd0 - bus.rs2) : bus.rs2;
    div_zero = (bus.rs2 == 32'd0);
    div_ovf  = !code[0] && (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);
    special  = is_div && (div_zero || div_ovf);
    // code[1] separates rem/remu from div/divu
    if (div_zero) special_val = code[1] ? bus.rs1 : 32'hFFFF_FFFF;
    else          special_val = code[1] ? 32'd0   : 32'h8000_0000;
    accept   = (state == S_IDLE) && bus.issue && !bus.kill;
  end

  // One iteration step of each datapath, unrolled BITS_PER_CYCLE times.
  logic [63:0] div_next;
  logic [32:0] rs;
`ifdef MULDIV_SEQ_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = 64'($signed({1'b0, ma_q}) * $signed({1'b0, mb_q}));
`else
  logic [63:0] mul_next;
  logic [32:0] sum;
  always_comb begin
    mul_next = acc;
    sum      = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      sum      = {1'b0, mul_next[63:32]} + (mul_next[0] ? {1'b0, ma_q} : 33'd0);
      mul_next = {sum, mul_next[31:1]};
    end
  end
`endif

  always_comb begin
    div_next = acc;
    rs       = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      rs = {div_next[63:32], div_next[31]};
      if (rs >= {1'b0, mb_q}) begin
        rs       = rs - {1'b0, mb_q};
        div_next = {rs[31:0], div_next[30:0], 1'b1};
      end else begin
        div_next = {rs[31:0], div_next[30:0], 1'b0};
      end
    end
  end

  // Sign fix-up and final selection; acc holds {remainder, quotient} after a divide.
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, fix_val;
  always_comb begin
    prod_s = neg_main_q ? (64'd0 - acc) : acc;
    quo_s  = neg_main_q ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_s  = neg_rem_q ? (32'd0 - acc[63:32]) : acc[63:32];
    case (code_q)
      3'd0:                fix_val = prod_s[31:0];
      3'd1, 3'd2, 3'd3:    fix_val = prod_s[63:32];
      3'd4, 3'd5:          fix_val = quo_s;
      default:             fix_val = rem_s;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = is_div ? (special ? S_DONE : S_DIV) : S_MUL;
`ifdef MULDIV_SEQ_FAST_MUL_EN
      S_MUL:  state_nxt = S_FIX;
`else
      S_MUL:  if (cnt == CW'(ITER - 1)) state_nxt = S_FIX;
`endif
      S_DIV:  if (cnt == CW'(ITER - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.kill && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      code_q     <= 3'd0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      acc        <= '0;
      cnt        <= '0;
      fixed_q    <= '0;
      result_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          code_q     <= code;
          neg_main_q <= sa ^ sb;
          neg_rem_q  <= sa;
          ma_q       <= abs_a;
          mb_q       <= abs_b;
          cnt        <= '0;
          acc        <= is_div ? {32'd0, abs_a} : {32'd0, abs_b};
          if (special) fixed_q <= special_val;
        end
        S_MUL: begin
`ifdef MULDIV_SEQ_FAST_MUL_EN
          acc <= fast_prod;
`else
          acc <= mul_next;
`endif
          cnt <= cnt + CW'(1);
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
        end
        S_FIX:  fixed_q <= fix_val;
        S_DONE: if (!bus.kill) result_q <= fixed_q;
        default: ;
      endcase
    end
  end

  // result shows the new value during the valid pulse and holds it afterwards.
  assign bus.ready        = (state == S_IDLE);
  assign bus.busy         = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign bus.result_valid = (state == S_DONE) && !bus.kill;
  assign bus.result       = bus.result_valid ? fixed_q : result_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table with hand-computed results plus
// kill, held-issue and mid-operation reset sequences.
module tb_muldiv_seq;
  localparam int BPC   = 1;
  localparam int LAT_N = 32 / BPC + 2;
`ifdef MULDIV_SEQ_FAST_MUL_EN
  localparam int LAT_M = 3;
`else
  localparam int LAT_M = LAT_N;
`endif
  localparam logic [7:0] OP_MUL = 8'h01, OP_MULH = 8'h02, OP_MULHSU = 8'h04, OP_MULHU = 8'h08;
  localparam logic [7:0] OP_DIV = 8'h10, OP_DIVU = 8'h20, OP_REM = 8'h40, OP_REMU = 8'h80;

  logic clock = 1'b0;
  logic reset = 1'b1;
  muldiv_seq_if bus();

  muldiv_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'd0;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Scoreboard: every result_valid pulse must match the oldest expected value.
  always @(negedge clock) begin
    if (!reset && bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got=0x%08h exp=none", bus.result);
      end else begin
        check32("result", bus.result, exp_q.pop_front());
      end
    end
  end

  task automatic add_vec(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called just after a falling edge; returns just after the accepting rising edge.
  task automatic issue_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.issue = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    @(posedge clock);
    #1 bus.issue = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat, input logic [31:0] exp);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (bus.result_valid === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_valid exp=valid_within_100", name);
    end else begin
      check_int({name, "_lat"}, cyc, exp_lat);
    end
    @(negedge clock);
    check32({name, "_pulse_end"}, {31'd0, bus.result_valid}, 32'd0);
    check32({name, "_held"}, bus.result, exp);
    last_exp = exp;
  endtask

  initial begin
    bit ok_low;
    bus.issue = 1'b0;
    bus.op    = 8'd0;
    bus.rs1   = 32'd0;
    bus.rs2   = 32'd0;
    bus.kill  = 1'b0;

    add_vec("mul_7x-3",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_M);
    add_vec("mulh_min_sq",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT_M);
    add_vec("mulhu_max_sq",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_M);
    add_vec("mulhsu_m1",     OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_M);
    add_vec("mulh_m1x2",     OP_MULH,   32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LAT_M);
    add_vec("mul_illegal0",  8'h00,     32'd3,          32'd4,         32'd12,        LAT_M);
    add_vec("mul_illegal2h", 8'h30,     32'd6,          32'd7,         32'd42,        LAT_M);
    add_vec("div_-7/2",      OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT_N);
    add_vec("rem_-7/2",      OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT_N);
    add_vec("divu_100/7",    OP_DIVU,   32'd100,        32'd7,         32'd14,        LAT_N);
    add_vec("remu_100/7",    OP_REMU,   32'd100,        32'd7,         32'd2,         LAT_N);
    add_vec("div_20/-3",     OP_DIV,    32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT_N);
    add_vec("rem_20/-3",     OP_REM,    32'd20,         32'hFFFF_FFFD, 32'd2,         LAT_N);
    add_vec("div_5/0",       OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    add_vec("divu_5/0",      OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    add_vec("remu_5/0",      OP_REMU,   32'd5,          32'd0,         32'd5,         1);
    add_vec("rem_5/0",       OP_REM,    32'd5,          32'd0,         32'd5,         1);
    add_vec("div_ovf",       OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_vec("rem_ovf",       OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check32("rst_ready",  {31'd0, bus.ready},        32'd1);
    check32("rst_busy",   {31'd0, bus.busy},         32'd0);
    check32("rst_valid",  {31'd0, bus.result_valid}, 32'd0);
    check32("rst_result", bus.result,                32'd0);
    check32("rst_state",  {29'd0, bus.dbg_state},    32'd0);

    // Kill in IDLE blocks the accept
    bus.kill = 1'b1;
    issue_op(OP_DIVU, 32'd100, 32'd7);
    bus.kill = 1'b0;
    @(negedge clock);
    check32("kill_vs_issue_ready", {31'd0, bus.ready}, 32'd1);
    check32("kill_vs_issue_busy",  {31'd0, bus.busy},  32'd0);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      issue_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(vecs[i].name, vecs[i].lat, vecs[i].exp);
    end

    // Kill mid-divide, then a fresh issue right after
    issue_op(OP_DIVU, 32'd100, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 10) bus.kill = 1'b1;
    end
    @(negedge clock);
    bus.kill = 1'b0;
    check32("kill_ready",  {31'd0, bus.ready}, 32'd1);
    check32("kill_busy",   {31'd0, bus.busy},  32'd0);
    check32("kill_result", bus.result,         last_exp);
    exp_q.push_back(32'd2);
    issue_op(OP_REMU, 32'd100, 32'd7);
    wait_valid("after_kill", LAT_N, 32'd2);

    // Issue held high across two operations
    exp_q.push_back(32'd14);
    bus.issue = 1'b1;
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    @(posedge clock);
    ok_low = 1;
    for (int k = 1; k <= LAT_N; k++) begin
      @(negedge clock);
      if (bus.ready !== 1'b0) ok_low = 0;
    end
    check32("held_ready_low", {31'd0, ok_low}, 32'd1);
    @(negedge clock);
    check32("held_ready_again", {31'd0, bus.ready}, 32'd1);
    exp_q.push_back(32'd14);
    @(posedge clock);
    #1 bus.issue = 1'b0;
    wait_valid("held_second", LAT_N, 32'd14);

    // Reset in the middle of a divide
    issue_op(OP_DIV, 32'd100, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 10) reset = 1'b1;
    end
    @(negedge clock);
    check32("midrst_ready",  {31'd0, bus.ready},        32'd1);
    check32("midrst_busy",   {31'd0, bus.busy},         32'd0);
    check32("midrst_valid",  {31'd0, bus.result_valid}, 32'd0);
    check32("midrst_result", bus.result,                32'd0);
    check32("midrst_state",  {29'd0, bus.dbg_state},    32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    check_int("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
